// File: rtl/apogee_mem_arb.sv
// -----------------------------------------------------------------------------
// apogee_mem_arb
//   Arbiter and access sequencer for the single byte-wide memory port of the
//   Apogee core. Three requesters share the port: the video DMA (read only),
//   the host file loader (write only) and the 8080 CPU (read/write). The block
//   owns the memory strobes, so only one access is ever in flight. Each access
//   holds exactly one strobe for ACC_CYC cycles and is followed by a one-cycle
//   completion slot that carries the owner's ack.
//
//   Priority is video > loader > CPU. The CPU is forced to win once it has
//   watched STARVE_MAX consecutive non-CPU grants while it was pending.
//
// Ports
//   clk, reset                 system clock (clk_sys), async active-high reset
//   cpu_req/we/addr/wdata      CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack         CPU read data (held) and completion pulse
//   vid_req/addr               video DMA read request
//   vid_rdata, vid_ack         video read data (held) and completion pulse
//   ldr_req/addr/wdata         loader write request
//   ldr_ack                    loader completion pulse
//   mem_addr/din/we/rd         memory controller command (registered)
//   mem_dout                   memory controller read data
//   grant                      0 none, 1 video, 2 loader, 3 CPU
//   busy                       high during ACCESS and DONE
// -----------------------------------------------------------------------------
module apogee_mem_arb #(
    parameter int ACC_CYC    = 4,   // strobe cycles per access, 1..15
    parameter int STARVE_MAX = 3    // non-CPU grants tolerated while CPU waits, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic [7:0]  vid_rdata,
    output logic        vid_ack,
    input  logic        ldr_req,
    input  logic [15:0] ldr_addr,
    input  logic [7:0]  ldr_wdata,
    output logic        ldr_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_VID  = 2'd1;
    localparam logic [1:0] G_LDR  = 2'd2;
    localparam logic [1:0] G_CPU  = 2'd3;

    localparam logic [3:0] ACC_LAST   = 4'(ACC_CYC - 1);
    localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] acc_cnt;      // strobe cycles remaining after the current one
    logic [3:0] starve_cnt;   // consecutive non-CPU grants while CPU pending
    logic [1:0] winner;
    logic       grant_now;

    // Winner among the live requests; only acted on in IDLE.
    always_comb begin
        winner = G_NONE;
        if (cpu_req && (starve_cnt == STARVE_TOP)) winner = G_CPU;
        else if (vid_req)                          winner = G_VID;
        else if (ldr_req)                          winner = G_LDR;
        else if (cpu_req)                          winner = G_CPU;
    end

    assign grant_now = (state == S_IDLE) && (winner != G_NONE);

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the strobes are plain flops on the async reset, so an
            // access in flight is cut off the instant reset rises and its ack
            // is never produced.
            state      <= S_IDLE;
            acc_cnt    <= '0;
            starve_cnt <= '0;
            grant      <= G_NONE;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_rd     <= 1'b0;
            cpu_ack    <= 1'b0;
            vid_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            cpu_rdata  <= '0;
            vid_rdata  <= '0;
        end else begin
            // The starve count only means something while the CPU is waiting.
            if (!cpu_req) begin
                starve_cnt <= '0;
            end else if (grant_now) begin
                if (winner == G_CPU)
                    starve_cnt <= '0;
                else if (starve_cnt != STARVE_TOP)
                    starve_cnt <= starve_cnt + 4'd1;
            end

            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            ldr_ack <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        state   <= S_ACCESS;
                        acc_cnt <= ACC_LAST;
                        grant   <= winner;
                        busy    <= 1'b1;
                        case (winner)
                            G_VID: begin
                                mem_addr <= vid_addr;
                                mem_din  <= '0;
                                mem_rd   <= 1'b1;
                            end
                            G_LDR: begin
                                mem_addr <= ldr_addr;
                                mem_din  <= ldr_wdata;
                                mem_we   <= 1'b1;
                            end
                            default: begin
                                mem_addr <= cpu_addr;
                                mem_din  <= cpu_wdata;
                                mem_we   <= cpu_we;
                                mem_rd   <= ~cpu_we;
                            end
                        endcase
                    end
                end

                S_ACCESS: begin
                    if (acc_cnt == 4'd0) begin
                        // Final strobe cycle: mem_dout is captured on this edge.
                        state  <= S_DONE;
                        mem_rd <= 1'b0;
                        mem_we <= 1'b0;
                        case (grant)
                            G_VID: begin
                                vid_ack   <= 1'b1;
                                vid_rdata <= mem_dout;
                            end
                            G_LDR: ldr_ack <= 1'b1;
                            G_CPU: begin
                                cpu_ack <= 1'b1;
                                if (mem_rd) cpu_rdata <= mem_dout;
                            end
                            default: ;
                        endcase
                    end else begin
                        acc_cnt <= acc_cnt - 4'd1;
                    end
                end

                S_DONE: begin
                    // Requests are ignored here; owners drop req on this edge.
                    state <= S_IDLE;
                    grant <= G_NONE;
                    busy  <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/apogee_mem_arb.md
Name: apogee_mem_arb

Overview:
- Arbiter and sequencer for the single byte-wide SDRAM-backed memory port of the Apogee core.
- Shares the port between three requesters:
  - the 8080 CPU (read/write);
  - the video DMA (read only; real-time, feeds the CRT character fetch);
  - the host file loader (write only, ROM/tape image download).
- Owns the memory strobes, so the sram controller never sees overlapping accesses. Each access occupies a fixed strobe window.

Parameters:
- ACC_CYC, 4, number of clk cycles the mem_rd/mem_we strobe is held per access (legal 1..15).
- STARVE_MAX, 3, consecutive non-CPU grants tolerated while the CPU is pending before the CPU is forced to win (legal 1..15).

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, valid when cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video DMA read request, level
- vid_addr  in  16  DMA address
- vid_rdata  out  8  DMA read data, valid when vid_ack=1
- vid_ack  out  1  one-cycle completion pulse
- ldr_req  in  1  loader write request, level
- ldr_addr  in  16  loader address
- ldr_wdata  in  8  loader write data
- ldr_ack  out  1  one-cycle completion pulse
- mem_addr  out  16  address to memory controller
- mem_din  out  8  write data to memory controller
- mem_we  out  1  write strobe
- mem_rd  out  1  read strobe
- mem_dout  in  8  read data from memory controller
- grant  out  2  current owner: 0 none, 1 video, 2 loader, 3 CPU
- busy  out  1  1 while in ACCESS or DONE

Behaviour:
Reset:
- All outputs 0; FSM in IDLE; strobe counter 0; starve counter 0.
- Reset asserted mid-access aborts immediately: strobes drop without waiting for a clock, and no ack is issued.

FSM states:
- IDLE → ACCESS when any req=1.
- ACCESS → DONE after ACC_CYC cycles.
- DONE → IDLE unconditionally.

Arbitration (IDLE only):
- Fixed priority: video > loader > CPU.
- Override: if starve_cnt == STARVE_MAX and cpu_req=1, the CPU wins.

Grant and access (ACCESS state):
- On the grant edge, latch the winner's address, data and direction into mem_addr/mem_din.
- mem_rd = 1 for video, or CPU with cpu_we=0. mem_we = 1 for loader, or CPU with cpu_we=1.
- Exactly one strobe is high for exactly ACC_CYC consecutive cycles.
- mem_addr and mem_din stay stable from the grant edge through DONE.

Completion (DONE state):
- Strobes are 0. The owner's ack is 1 for exactly this cycle.
- For reads, the owner's rdata is loaded from mem_dout sampled on the final ACCESS cycle and held until that owner's next read completes.
- Latency: request first seen high at edge N.
  - Strobe high for cycles N+1 … N+ACC_CYC.
  - ack high in cycle N+ACC_CYC+1.
  - Next grant earliest at edge N+ACC_CYC+2.

Requester rules:
- A requester must deassert req (or present a new access) on the edge at which it samples ack=1. Req is not sampled in DONE.
- Dropping req during ACCESS does not abort the access; ack still pulses.
- Changing address or data while granted has no effect, since they are latched.

Starve counter (saturating at STARVE_MAX):
- Increments on each grant to video/loader while cpu_req=1.
- Clears on any CPU grant, or in any cycle with cpu_req=0.

grant / busy:
- grant holds the owner encoding from the grant edge through DONE, and is 0 in IDLE.
- busy = 1 in ACCESS and DONE.

Simultaneous requests: all three high in the same IDLE cycle → video first, then loader, then CPU, subject to the starve override.

Test Plan:
- CPU read, ACC_CYC=4: cpu_req=1, cpu_we=0, addr 0x1234; memory model returns 0xA5 → mem_rd high 4 cycles with mem_addr=0x1234; cpu_ack one cycle later with cpu_rdata=0xA5; grant=3 during access.
- Simultaneous requests: vid, ldr and cpu all raised in the same cycle → grants in order 1, 2, 3; each ack 6 cycles apart; no strobe overlap; mem_we asserted only for the loader and CPU-write accesses.
- Starvation, STARVE_MAX=3: vid_req held high continuously with cpu_req=1 → exactly 3 video grants, then a CPU grant, then video resumes.
- Loader write: ldr_addr=0xF800, ldr_wdata=0x3C → mem_we high 4 cycles with mem_din=0x3C; ldr_ack pulses; vid_rdata/cpu_rdata unchanged.
- Reset mid-access: assert reset during the 2nd ACCESS cycle of a CPU write → mem_we drops immediately; no cpu_ack; after release, grant=0 and busy=0, and a new request starts normally.
- ACC_CYC=1 and back-to-back requests: CPU read with req re-asserted after ack → strobe 1 cycle, ack next cycle, next grant on the following edge (3-cycle period).
